seg_disp_mux: RTL and testbench

SEG_DISP_MUX -- requirements
Module: seg_disp_mux

---
 rtl/seg_disp_mux.sv | 100 ++++++++++
 tb/tb_seg_disp_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_mux.sv
// Two-digit seven-segment display multiplexer. It accepts a frame of ones/tens
// patterns, holds each frame for a minimum time, and time-multiplexes the two digits.
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   BLANK | no frame seen since reset; both digits show a dash, ready for a frame
//   HOLD  | frame just accepted; hold counter runs down, upstream is stalled
//   WAIT  | hold time met; last frame stays on display, ready for the next frame
module seg_disp_mux #(
    parameter int REFRESH_DIV = 4,
    parameter int MIN_HOLD    = 16,
    parameter int LZ_BLANK    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [6:0] s_data_ones,
    input  logic [6:0] s_data_tens,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int HW = (MIN_HOLD > 2) ? $clog2(MIN_HOLD) : 1;
    localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_DIV - 1);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(MIN_HOLD - 1);
    localparam logic [6:0]    SEG_DASH  = 7'b0000001;
    localparam logic [6:0]    SEG_ZERO  = 7'b1111110;

    typedef enum logic [1:0] {BLANK, HOLD, WAIT} state_t;

    state_t        state;
    logic [6:0]    ones_reg;
    logic [6:0]    tens_reg;
    logic [RW-1:0] refresh_cnt;
    logic [HW-1:0] hold_cnt;
    logic          digit_sel;
    logic          transfer;

    assign transfer = s_valid & s_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BLANK;
            s_ready     <= 1'b0;
            seg         <= 7'b0000000;
            an          <= 2'b00;
            ones_reg    <= SEG_DASH;
            tens_reg    <= SEG_DASH;
            refresh_cnt <= '0;
            hold_cnt    <= '0;
            digit_sel   <= 1'b0;
        end else begin
            if (refresh_cnt == REF_LAST) begin
                refresh_cnt <= '0;
                digit_sel   <= ~digit_sel;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end

            // Display uses pre-edge select and patterns, so a capture shows one edge later.
            if (!digit_sel) begin
                seg <= ones_reg;
                an  <= 2'b01;
            end else begin
                seg <= (LZ_BLANK != 0 && tens_reg == SEG_ZERO) ? 7'b0000000 : tens_reg;
                an  <= 2'b10;
            end

            case (state)
                BLANK, WAIT: begin
                    if (transfer) begin
                        ones_reg <= s_data_ones;
                        tens_reg <= s_data_tens;
                        hold_cnt <= HOLD_LOAD;
                        state    <= HOLD;
                        s_ready  <= 1'b0;
                    end else begin
                        s_ready  <= 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        state   <= WAIT;
                        s_ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                        s_ready  <= 1'b0;
                    end
                end
                default: begin
                    state   <= BLANK;
                    s_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_disp_mux.sv
// Directed bench for seg_disp_mux at REFRESH_DIV=4, MIN_HOLD=16, LZ_BLANK=1.
module tb_seg_disp_mux;

    localparam logic [6:0] DASH = 7'b0000001;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [6:0] s_data_ones = 7'h00;
    logic [6:0] s_data_tens = 7'h00;
    logic [6:0] seg;
    logic [1:0] an;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    seg_disp_mux #(.REFRESH_DIV(4), .MIN_HOLD(16), .LZ_BLANK(1)) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data_ones (s_data_ones),
        .s_data_tens (s_data_tens),
        .seg         (seg),
        .an          (an)
    );

    // Rising edges since reset release; after edge k the enabled digit is set by edge k-1.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic logic [1:0] exp_an(int k);
        return ((((k - 1) / 4) % 2) != 0) ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [6:0] exp_seg(logic [1:0] a, logic [6:0] o, logic [6:0] t);
        if (a == 2'b01) return o;
        return (t == 7'b1111110) ? 7'b0000000 : t;
    endfunction

    task automatic test_reset();
        s_valid = 1'b0;
        #1 reset = 1'b1;
        #11;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", s_ready); end
        checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL reset_seg got=%b exp=0000000", seg); end
        checks++; if (an !== 2'b00) begin failures++; $display("FAIL reset_an got=%b exp=00", an); end
    endtask

    task automatic test_idle();
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL idle_ready cyc=%0d got=%b exp=1", cyc, s_ready); end
            checks++; if (an !== exp_an(cyc)) begin failures++; $display("FAIL idle_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc)); end
            checks++; if (seg !== DASH) begin failures++; $display("FAIL idle_seg cyc=%0d got=%b exp=%b", cyc, seg, DASH); end
        end
    endtask

    // Sends one frame, keeps s_valid high with junk during HOLD, and checks hold length and display.
    task automatic test_frame(input logic [6:0] o, input logic [6:0] t);
        int w;
        int k;
        int lows;
        w = 0;
        while (s_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL frame_ready_timeout got=%b exp=1", s_ready); end
        s_valid = 1'b1; s_data_ones = o; s_data_tens = t;
        k = cyc;
        @(negedge clk);
        lows = 0;
        while (s_ready === 1'b0 && lows < 40) begin
            lows++;
            s_data_ones = 7'h2A ^ 7'(lows);
            s_data_tens = 7'h15 ^ 7'(lows);
            if (cyc >= k + 2) begin
                checks++; if (an !== exp_an(cyc)) begin failures++; $display("FAIL frame_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc)); end
                checks++; if (seg !== exp_seg(exp_an(cyc), o, t)) begin failures++; $display("FAIL frame_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg(exp_an(cyc), o, t)); end
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++; if (lows != 16) begin failures++; $display("FAIL frame_hold_len got=%0d exp=16", lows); end
        repeat (8) begin
            @(negedge clk);
            checks++; if (seg !== exp_seg(exp_an(cyc), o, t)) begin failures++; $display("FAIL wait_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg(exp_an(cyc), o, t)); end
            checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL wait_ready cyc=%0d got=%b exp=1", cyc, s_ready); end
        end
    endtask

    task automatic test_back_to_back();
        int tx[$];
        logic [6:0] last_o;
        logic [6:0] last_t;
        last_o = 7'h00; last_t = 7'h00;
        for (int i = 0; i < 60; i++) begin
            s_valid = 1'b1;
            s_data_ones = i[6:0];
            s_data_tens = 7'h40 | {1'b0, i[5:0]};
            if (s_ready === 1'b1) begin
                tx.push_back(cyc + 1);
                last_o = s_data_ones;
                last_t = s_data_tens;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        checks++; if (tx.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", tx.size()); end
        for (int j = 1; j < tx.size(); j++) begin
            checks++; if (tx[j] - tx[j-1] != 17) begin failures++; $display("FAIL b2b_interval idx=%0d got=%0d exp=17", j, tx[j] - tx[j-1]); end
        end
        checks++; if (last_o !== 7'd51) begin failures++; $display("FAIL b2b_last_frame got=%0d exp=51", last_o); end
        repeat (8) begin
            @(negedge clk);
            checks++; if (seg !== exp_seg(exp_an(cyc), 7'd51, 7'h73)) begin failures++; $display("FAIL b2b_seg cyc=%0d got=%b exp=%b", cyc, seg, exp_seg(exp_an(cyc), 7'd51, 7'h73)); end
        end
    endtask

    task automatic test_reset_mid_hold();
        int w;
        w = 0;
        while (s_ready !== 1'b1 && w < 40) begin @(negedge clk); w++; end
        s_valid = 1'b1; s_data_ones = 7'b1011011; s_data_tens = 7'b1101101;
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rmh_in_hold got=%b exp=0", s_ready); end
        repeat (4) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rmh_ready got=%b exp=0", s_ready); end
        checks++; if (seg !== 7'b0000000) begin failures++; $display("FAIL rmh_seg got=%b exp=0000000", seg); end
        checks++; if (an !== 2'b00) begin failures++; $display("FAIL rmh_an got=%b exp=00", an); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL rmh_rel_ready got=%b exp=1", s_ready); end
        checks++; if (an !== 2'b01) begin failures++; $display("FAIL rmh_rel_an got=%b exp=01", an); end
        repeat (8) begin
            checks++; if (seg !== DASH) begin failures++; $display("FAIL rmh_dash cyc=%0d got=%b exp=%b", cyc, seg, DASH); end
            @(negedge clk);
        end
    endtask

    task automatic test_wrap();
        int w;
        w = 0;
        while ((s_ready !== 1'b1 || (cyc % 8) != 3) && w < 40) begin @(negedge clk); w++; end
        checks++; if (w >= 40) begin failures++; $display("FAIL wrap_align_timeout got=%0d exp<40", w); end
        s_valid = 1'b1; s_data_ones = 7'b0110011; s_data_tens = 7'b1011011;
        @(negedge clk);
        s_valid = 1'b0;
        checks++; if (an !== 2'b01) begin failures++; $display("FAIL wrap_an_before got=%b exp=01", an); end
        checks++; if (seg !== DASH) begin failures++; $display("FAIL wrap_seg_before got=%b exp=%b", seg, DASH); end
        @(negedge clk);
        checks++; if (an !== 2'b10) begin failures++; $display("FAIL wrap_an_after got=%b exp=10", an); end
        checks++; if (seg !== 7'b1011011) begin failures++; $display("FAIL wrap_seg_after got=%b exp=1011011", seg); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame(7'b1011011, 7'b1101101);
        test_frame(7'b0110000, 7'b1111110);
        test_frame(7'b0000001, 7'b0000001);
        test_back_to_back();
        test_reset_mid_hold();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t exp=finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
